// File: rtl/brute_force_gen.sv
// Synchronous candidate-password generator: enumerates [CHAR_MIN..CHAR_MAX]^1..MAX_LEN, digit 0 least significant.
// Optional feature macro: CAND_COUNT_EN adds a saturating 64-bit accepted-candidate counter on port cand_count.
module brute_force_gen #(
  parameter int unsigned MAX_LEN  = 8,
  parameter int unsigned PW_BYTES = 16,
  parameter logic [7:0]  CHAR_MIN = 8'h61,
  parameter logic [7:0]  CHAR_MAX = 8'h7A,
  parameter int unsigned LEN_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            start_offset,
  input  logic [7:0]            stride,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*PW_BYTES-1:0] password,
  output logic [LEN_W-1:0]      length,
  output logic                  busy,
  output logic                  done
`ifdef CAND_COUNT_EN
  ,
  output logic [63:0]           cand_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       digit_q [PW_BYTES];
  logic [7:0]       digit_d [PW_BYTES];
  logic [7:0]       nxt     [PW_BYTES];
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       off_q, off_d;
  logic [7:0]       stride_q, stride_d;

  logic             accept;
  logic             carry;
  logic [8:0]       first9;
  logic [8:0]       sum9;
  logic [31:0]      len_w;

  assign accept = (state_q == S_RUN) && out_ready;
  assign first9 = {1'b0, CHAR_MIN} + {1'b0, start_offset};
  assign sum9   = {1'b0, digit_q[0]} + {1'b0, stride_q};
  assign len_w  = 32'(len_q);

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    nxt      = digit_q;
    len_d    = len_q;
    off_d    = off_q;
    stride_d = stride_q;
    carry    = 1'b0;

    if (start) begin
      off_d    = start_offset;
      stride_d = (stride == 8'd0) ? 8'd1 : stride;
      len_d    = LEN_W'(1);
      for (int unsigned i = 0; i < PW_BYTES; i++) digit_d[i] = '0;
      digit_d[0] = first9[7:0];
      state_d    = (first9 > {1'b0, CHAR_MAX}) ? S_DONE : S_RUN;
    end else if (accept) begin
      // Digit 0 restarts at this core's slice origin, not CHAR_MIN, so cores stay disjoint.
      if (sum9 > {1'b0, CHAR_MAX}) begin
        nxt[0] = CHAR_MIN + off_q;
        carry  = 1'b1;
      end else begin
        nxt[0] = sum9[7:0];
      end
      for (int unsigned i = 1; i < PW_BYTES; i++) begin
        if (carry && (i < len_w)) begin
          if (digit_q[i] == CHAR_MAX) begin
            nxt[i] = CHAR_MIN;
          end else begin
            nxt[i] = digit_q[i] + 8'd1;
            carry  = 1'b0;
          end
        end
      end
      if (!carry) begin
        digit_d = nxt;
      end else if (len_w < MAX_LEN) begin
        for (int unsigned i = 0; i < PW_BYTES; i++) begin
          if (i == len_w) nxt[i] = CHAR_MIN;
        end
        digit_d = nxt;
        len_d   = len_q + LEN_W'(1);
      end else begin
        // Space exhausted: keep the last candidate visible.
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      digit_q  <= '{default: '0};
      len_q    <= '0;
      off_q    <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      len_q    <= len_d;
      off_q    <= off_d;
      stride_q <= stride_d;
    end
  end

`ifdef CAND_COUNT_EN
  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start)                          count_d = '0;
    else if (accept && (count_q != '1)) count_d = count_q + 64'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign cand_count = count_q;
`endif

  always_comb begin
    password = '0;
    for (int unsigned i = 0; i < PW_BYTES; i++) password[8*i +: 8] = digit_q[i];
  end

  assign length    = len_q;
  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_brute_force_gen.sv
// Self-checking bench for brute_force_gen with charset 'a'..'c', MAX_LEN=2; checks against an enumerating model.
module tb_brute_force_gen;

  localparam int MAX_LEN  = 2;
  localparam int PW_BYTES = 4;
  localparam int CHAR_MIN = 'h61;
  localparam int CHAR_MAX = 'h63;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [7:0]  start_offset, stride;
  logic        out_valid, busy, done;
  logic [31:0] password;
  logic [3:0]  length;
`ifdef CAND_COUNT_EN
  logic [63:0] cand_count;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] exp_pw[$];
  int          exp_len[$];

  typedef struct {
    int off;
    int str;
    int n;
  } vec_t;
  vec_t vecs[10];

  brute_force_gen #(
    .MAX_LEN (MAX_LEN),
    .PW_BYTES(PW_BYTES),
    .CHAR_MIN(8'h61),
    .CHAR_MAX(8'h63),
    .LEN_W   (4)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .start_offset(start_offset),
    .stride      (stride),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .password    (password),
    .length      (length),
    .busy        (busy),
    .done        (done)
`ifdef CAND_COUNT_EN
    ,
    .cand_count  (cand_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every string of length 1..MAX_LEN in numeric order (digit 0 fastest),
  // keeping those whose digit 0 lies in this core's offset/stride slice.
  task automatic build_model(input int off, input int str);
    int k, s, total, d0, r;
    logic [31:0] pw;
    k = CHAR_MAX - CHAR_MIN + 1;
    s = (str == 0) ? 1 : str;
    exp_pw.delete();
    exp_len.delete();
    for (int L = 1; L <= MAX_LEN; L++) begin
      total = 1;
      for (int j = 0; j < L; j++) total = total * k;
      for (int n = 0; n < total; n++) begin
        d0 = n % k;
        if (d0 >= off && ((d0 - off) % s) == 0) begin
          pw = '0;
          r  = n;
          for (int b = 0; b < L; b++) begin
            pw[8*b +: 8] = 8'(CHAR_MIN + r % k);
            r = r / k;
          end
          exp_pw.push_back(pw);
          exp_len.push_back(L);
        end
      end
    end
  endtask

  task automatic do_start(input int off, input int str);
    @(negedge clk);
    start        = 1'b1;
    start_offset = 8'(off);
    stride       = 8'(str);
    out_ready    = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int off, input int str, input int n_exp, input bit rnd_ready);
    int          total, got;
    logic [31:0] last_pw, prev_pw;
    logic [3:0]  prev_len;
    bit          held;
    build_model(off, str);
    total = exp_pw.size();
    got   = 0;
    held  = 0;
    last_pw = '0;
    prev_pw = '0;
    prev_len = '0;
    if (n_exp >= 0) check("model_count", 64'(total), 64'(n_exp));
    do_start(off, str);
    for (int cyc = 0; cyc < 400 && out_valid; cyc++) begin
      if (held) begin
        check("hold_pw", 64'(password), 64'(prev_pw));
        check("hold_len", 64'(length), 64'(prev_len));
      end
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_ready) begin
        if (exp_pw.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_cand: got %0h expected none", password);
        end else begin
          check("cand_pw", 64'(password), 64'(exp_pw.pop_front()));
          check("cand_len", 64'(length), 64'(exp_len.pop_front()));
        end
        last_pw = password;
        got++;
      end
      held     = !out_ready;
      prev_pw  = password;
      prev_len = length;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("accepts", 64'(got), 64'(total));
    check("end_valid", 64'(out_valid), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("end_done", 64'(done), 64'd1);
    if (total > 0) check("end_pw_held", 64'(password), 64'(last_pw));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{off: 0, str: 1, n: 12};
    vecs[1] = '{off: 0, str: 2, n: 8};
    vecs[2] = '{off: 1, str: 2, n: 4};
    vecs[3] = '{off: 2, str: 2, n: 4};
    vecs[4] = '{off: 3, str: 1, n: 0};
    vecs[5] = '{off: 0, str: 0, n: 12};
    vecs[6] = '{off: 1, str: 1, n: 8};
    vecs[7] = '{off: 2, str: 1, n: 4};
    vecs[8] = '{off: 0, str: 3, n: 4};
    vecs[9] = '{off: 9, str: 2, n: 0};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    start_offset = '0; stride = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pw", 64'(password), 64'd0);
    check("rst_len", 64'(length), 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i].off, vecs[i].str, vecs[i].n, 1'b0);

`ifdef CAND_COUNT_EN
    run_vec(0, 1, 12, 1'b0);
    check("cnt_after_run", cand_count, 64'd12);
    do_start(0, 1);
    check("cnt_cleared", cand_count, 64'd0);
`endif

    // Backpressure on "ba": a,b,c,aa accepted, then stall.
    do_start(0, 1);
    check("bp_first", 64'(password), 64'h61);
    check("bp_first_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_pw", 64'(password), 64'h6162);
      check("bp_len", 64'(length), 64'd2);
      check("bp_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_next", 64'(password), 64'h6163);

    // Reset mid-run, then a clean restart.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_pw", 64'(password), 64'd0);
    check("mid_rst_len", 64'(length), 64'd0);
    run_vec(0, 1, 12, 1'b1);

    // Restart while busy takes priority over the pending accept.
    do_start(1, 1);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; start_offset = 8'd0; stride = 8'd1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    check("restart_pw", 64'(password), 64'h61);
    check("restart_len", 64'(length), 64'd1);
    check("restart_done", 64'(done), 64'd0);

    for (int t = 0; t < 6; t++) run_vec(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
